dff_share_arbiter: RTL and testbench

- Round-robin arbiter and write sequencer for a shared WIDTH-bit D-flip-flop register.
- Up to N_REQ requesters each present data plus a request line. The block grants exactly one requester at a time and commits that requester's data into the shared register, q.
- The block then acknowledges the write and rotates priority to the next requester.
- It sits between requester logic and the flip-flop bank it owns internally. q is the only observable register state.

---
 rtl/dff_share_arbiter.sv | 137 +++++++++++++
 tb/tb_dff_share_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter and write sequencer for a shared WIDTH-bit register.
// Each transaction runs IDLE -> GRANT -> COMMIT. The winner's data is written
// into q, and priority then rotates to the requester after the winner.
module dff_share_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned OWNER_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         ack,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [OWNER_W-1:0]       owner,
  output logic                     busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t               state_q;
  logic [OWNER_W-1:0]   ptr_q;
  logic [OWNER_W-1:0]   sel_q;
  logic [N_REQ-1:0]     grant_q;
  logic [N_REQ-1:0]     ack_q;
  logic [WIDTH-1:0]     data_q;
  logic                 valid_q;
  logic [OWNER_W-1:0]   owner_q;
  logic                 busy_q;

  logic [OWNER_W-1:0]   sel_d;
  logic [OWNER_W-1:0]   sel_hi;
  logic [OWNER_W-1:0]   sel_lo;
  logic                 found_hi;
  logic [OWNER_W-1:0]   ptr_d;
  logic [WIDTH-1:0]     wdata_sel_c;
  logic                 req_sel_c;

  // Rotating priority: lowest set index at or above ptr wins, else lowest overall.
  always_comb begin
    sel_hi   = '0;
    sel_lo   = '0;
    found_hi = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        sel_lo = OWNER_W'(j);
        if (OWNER_W'(j) >= ptr_q) begin
          sel_hi   = OWNER_W'(j);
          found_hi = 1'b1;
        end
      end
    end
    sel_d = found_hi ? sel_hi : sel_lo;
  end

  // Data slice and request bit of the latched winner.
  always_comb begin
    wdata_sel_c = '0;
    req_sel_c   = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (OWNER_W'(j) == sel_q) begin
        wdata_sel_c = wdata[j*WIDTH +: WIDTH];
        req_sel_c   = req[j];
      end
    end
  end

  // The pointer wraps explicitly so that non-power-of-two N_REQ is handled.
  always_comb begin
    ptr_d = (sel_q == OWNER_W'(N_REQ - 1)) ? '0 : sel_q + OWNER_W'(1);
  end

  // Arbitration FSM with registered grant, ack, data and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            sel_q   <= sel_d;
            grant_q <= N_REQ'(1) << sel_d;
            busy_q  <= 1'b1;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (req_sel_c) begin
            state_q <= ST_COMMIT;
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          data_q  <= wdata_sel_c;
          valid_q <= 1'b1;
          owner_q <= sel_q;
          ack_q   <= N_REQ'(1) << sel_q;
          grant_q <= '0;
          ptr_q   <= ptr_d;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign ack     = ack_q;
  assign q       = data_q;
  assign q_valid = valid_q;
  assign owner   = owner_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter using hand-computed expectations.
module tb_dff_share_arbiter;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned OWNER_W = 2;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [OWNER_W-1:0]     owner;
  logic                   busy;

  int checks;
  int errors;

  dff_share_arbiter #(
    .N_REQ  (N_REQ),
    .WIDTH  (WIDTH),
    .OWNER_W(OWNER_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .wdata  (wdata),
    .grant  (grant),
    .ack    (ack),
    .q      (q),
    .q_valid(q_valid),
    .owner  (owner),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_slice(input int idx, input logic [WIDTH-1:0] v);
    wdata[idx*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    logic [3:0] exp_owner [5];
    logic [7:0] exp_q     [5];
    exp_owner = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    exp_q     = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = '0;
    wdata  = '0;

    // Reset held for three cycles.
    tick(); tick(); tick();
    chk("rst_grant",   32'(grant),   32'h0);
    chk("rst_ack",     32'(ack),     32'h0);
    chk("rst_q",       32'(q),       32'h00);
    chk("rst_q_valid", 32'(q_valid), 32'h0);
    chk("rst_owner",   32'(owner),   32'h0);
    chk("rst_busy",    32'(busy),    32'h0);

    // Reset asserted in GRANT aborts the transaction.
    rst = 1'b0;
    tick();
    req = 4'b0001;
    set_slice(0, 8'h77);
    tick();
    chk("midrst_grant_before", 32'(grant), 32'h1);
    chk("midrst_busy_before",  32'(busy),  32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_grant_async", 32'(grant), 32'h0);
    chk("midrst_busy_async",  32'(busy),  32'h0);
    tick(); tick();
    chk("midrst_ack",     32'(ack),     32'h0);
    chk("midrst_q",       32'(q),       32'h00);
    chk("midrst_q_valid", 32'(q_valid), 32'h0);
    req = '0;
    rst = 1'b0;
    tick();

    // Single requester: grant after one edge, commit after two more.
    req = 4'b0001;
    set_slice(0, 8'hA5);
    tick();
    chk("single_grant_e1", 32'(grant), 32'h1);
    chk("single_ack_e1",   32'(ack),   32'h0);
    chk("single_busy_e1",  32'(busy),  32'h1);
    tick();
    chk("single_grant_e2", 32'(grant), 32'h1);
    chk("single_q_e2",     32'(q),     32'h00);
    tick();
    chk("single_q",       32'(q),       32'hA5);
    chk("single_ack",     32'(ack),     32'h1);
    chk("single_owner",   32'(owner),   32'h0);
    chk("single_q_valid", 32'(q_valid), 32'h1);
    chk("single_grant_off", 32'(grant), 32'h0);
    chk("single_busy_off",  32'(busy),  32'h0);
    req = '0;
    tick();
    chk("single_ack_pulse", 32'(ack), 32'h0);

    // Reset again so the pointer restarts at requester 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // All four requesting: strict rotation, one commit every three cycles.
    set_slice(0, 8'h10);
    set_slice(1, 8'h21);
    set_slice(2, 8'h32);
    set_slice(3, 8'h43);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'h1 << exp_owner[k]);
      tick();
      tick();
      chk("rr_q",     32'(q),     32'(exp_q[k]));
      chk("rr_owner", 32'(owner), 32'(exp_owner[k]));
      chk("rr_ack",   32'(ack),   32'h1 << exp_owner[k]);
      chk("rr_idle_gap", 32'(grant), 32'h0);
    end

    // Wrap-around: serve 3 (ptr goes to 0), then 1001 serves 0 before 3.
    req = 4'b1000;
    tick();
    chk("wrap_grant3", 32'(grant), 32'h8);
    tick(); tick();
    chk("wrap_owner3", 32'(owner), 32'h3);
    chk("wrap_q3",     32'(q),     32'h43);
    req = 4'b1001;
    tick();
    chk("wrap_grant_first", 32'(grant), 32'h1);
    tick(); tick();
    chk("wrap_owner_first", 32'(owner), 32'h0);
    chk("wrap_q_first",     32'(q),     32'h10);
    tick();
    chk("wrap_grant_second", 32'(grant), 32'h8);
    tick(); tick();
    chk("wrap_owner_second", 32'(owner), 32'h3);
    chk("wrap_ack_second",   32'(ack),   32'h8);
    req = '0;
    tick();

    // Withdrawal during GRANT: back to IDLE, no ack, state kept.
    req = 4'b0100;
    tick();
    chk("wd_grant", 32'(grant), 32'h4);
    req = '0;
    tick();
    chk("wd_grant_clr", 32'(grant), 32'h0);
    chk("wd_busy",      32'(busy),  32'h0);
    chk("wd_ack0",      32'(ack),   32'h0);
    tick();
    chk("wd_ack1",  32'(ack),   32'h0);
    chk("wd_q",     32'(q),     32'h43);
    chk("wd_owner", 32'(owner), 32'h3);
    // Pointer unchanged at 0: with 0101 pending, requester 0 wins.
    req = 4'b0101;
    tick();
    chk("wd_ptr_grant", 32'(grant), 32'h1);
    tick(); tick();
    chk("wd_ptr_owner", 32'(owner), 32'h0);
    req = 4'b0100;
    tick();
    chk("wd_retry_grant", 32'(grant), 32'h4);
    tick(); tick();
    chk("wd_retry_q",     32'(q),     32'h32);
    chk("wd_retry_owner", 32'(owner), 32'h2);
    chk("wd_retry_ack",   32'(ack),   32'h4);
    req = '0;
    tick();

    // Data sampled at the COMMIT edge, not at grant.
    set_slice(1, 8'h55);
    req = 4'b0010;
    tick();
    chk("ds_grant", 32'(grant), 32'h2);
    set_slice(1, 8'h66);
    tick(); tick();
    chk("ds_q",     32'(q),     32'h66);
    chk("ds_owner", 32'(owner), 32'h1);
    chk("ds_ack",   32'(ack),   32'h2);
    req = '0;
    tick();
    chk("ds_ack_pulse", 32'(ack), 32'h0);
    chk("ds_busy",      32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
